display_bcd_driver: RTL and testbench

//   Downstream display stage for the datapath system's 8-bit display bus.

---
 rtl/display_bcd_driver.sv | 178 +++++++++++++++++
 tb/tb_display_bcd_driver.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/display_bcd_driver.sv
// Captures an 8-bit bus value, converts it to 3-digit BCD by sequential double-dabble and
// scans it onto a 3-digit common-anode 7-segment display. Define DISPLAY_BCD_BLANK_EN to blank leading zeros.
module display_bcd_driver #(
  parameter int DATAWIDTH_BUS     = 8,
  parameter int DATAWIDTH_REFRESH = 16,
  parameter int REFRESH_COUNT     = 50000
) (
  input  logic                     DISPLAY_BCD_CLOCK_50,
  input  logic                     DISPLAY_BCD_Reset_InLow,
  input  logic [DATAWIDTH_BUS-1:0] DISPLAY_BCD_Data_In,
  input  logic                     DISPLAY_BCD_Load_In,
  output logic                     DISPLAY_BCD_Busy_Out,
  output logic                     DISPLAY_BCD_Done_Out,
  output logic [11:0]              DISPLAY_BCD_BCD_Out,
  output logic [6:0]               DISPLAY_BCD_Seg_Out,
  output logic [2:0]               DISPLAY_BCD_Anode_Out
);

  localparam int CNT_W = $clog2(DATAWIDTH_BUS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONVERT,
    S_DONE
  } state_t;

  state_t                   r_state, w_state_next;
  logic [DATAWIDTH_BUS-1:0] r_bin, w_bin_next;
  logic [11:0]              r_scratch, w_scratch_next;
  logic [CNT_W-1:0]         r_bit_cnt, w_bit_cnt_next;
  logic [11:0]              r_bcd;
  logic                     r_done, w_done_next;
  logic                     w_bcd_load;
  logic [11:0]              w_adj;

  logic [DATAWIDTH_REFRESH-1:0] r_refresh_cnt;
  logic                         w_refresh_wrap;
  logic [1:0]                   r_digit_idx;
  logic [3:0]                   w_nibble;
  logic [2:0]                   w_anode;
  logic                         w_blank;
  logic [6:0]                   r_seg;
  logic [2:0]                   r_anode;

  function automatic logic [6:0] decode_digit(input logic [3:0] i_digit);
    case (i_digit)
      4'd0:    decode_digit = 7'b1000000;
      4'd1:    decode_digit = 7'b1111001;
      4'd2:    decode_digit = 7'b0100100;
      4'd3:    decode_digit = 7'b0110000;
      4'd4:    decode_digit = 7'b0011001;
      4'd5:    decode_digit = 7'b0010010;
      4'd6:    decode_digit = 7'b0000010;
      4'd7:    decode_digit = 7'b1111000;
      4'd8:    decode_digit = 7'b0000000;
      4'd9:    decode_digit = 7'b0010000;
      default: decode_digit = 7'b1111111;
    endcase
  endfunction

  // Add-3 correction applied to each scratch nibble before the shift.
  always_comb begin
    w_adj[3:0]  = (r_scratch[3:0]  >= 4'd5) ? r_scratch[3:0]  + 4'd3 : r_scratch[3:0];
    w_adj[7:4]  = (r_scratch[7:4]  >= 4'd5) ? r_scratch[7:4]  + 4'd3 : r_scratch[7:4];
    w_adj[11:8] = (r_scratch[11:8] >= 4'd5) ? r_scratch[11:8] + 4'd3 : r_scratch[11:8];
  end

  always_comb begin
    w_state_next   = r_state;
    w_bin_next     = r_bin;
    w_scratch_next = r_scratch;
    w_bit_cnt_next = r_bit_cnt;
    w_done_next    = 1'b0;
    w_bcd_load     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (DISPLAY_BCD_Load_In) begin
          w_bin_next     = DISPLAY_BCD_Data_In;
          w_scratch_next = 12'h000;
          w_bit_cnt_next = '0;
          w_state_next   = S_CONVERT;
        end
      end
      S_CONVERT: begin
        w_scratch_next = {w_adj[10:0], r_bin[DATAWIDTH_BUS-1]};
        w_bin_next     = {r_bin[DATAWIDTH_BUS-2:0], 1'b0};
        w_bit_cnt_next = r_bit_cnt + 1'b1;
        if (r_bit_cnt == CNT_W'(DATAWIDTH_BUS - 1)) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        w_done_next  = 1'b1;
        w_bcd_load   = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge DISPLAY_BCD_CLOCK_50 or negedge DISPLAY_BCD_Reset_InLow) begin
    if (!DISPLAY_BCD_Reset_InLow) begin
      r_state   <= S_IDLE;
      r_bin     <= '0;
      r_scratch <= 12'h000;
      r_bit_cnt <= '0;
      r_bcd     <= 12'h000;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_bin     <= w_bin_next;
      r_scratch <= w_scratch_next;
      r_bit_cnt <= w_bit_cnt_next;
      r_done    <= w_done_next;
      if (w_bcd_load) begin
        r_bcd <= r_scratch;
      end
    end
  end

  assign w_refresh_wrap = (r_refresh_cnt == DATAWIDTH_REFRESH'(REFRESH_COUNT - 1));

  always_ff @(posedge DISPLAY_BCD_CLOCK_50 or negedge DISPLAY_BCD_Reset_InLow) begin
    if (!DISPLAY_BCD_Reset_InLow) begin
      r_refresh_cnt <= '0;
      r_digit_idx   <= 2'd0;
    end else if (w_refresh_wrap) begin
      r_refresh_cnt <= '0;
      r_digit_idx   <= (r_digit_idx == 2'd2) ? 2'd0 : r_digit_idx + 2'd1;
    end else begin
      r_refresh_cnt <= r_refresh_cnt + 1'b1;
    end
  end

  always_comb begin
    w_nibble = r_bcd[3:0];
    w_anode  = 3'b110;
    case (r_digit_idx)
      2'd1: begin
        w_nibble = r_bcd[7:4];
        w_anode  = 3'b101;
      end
      2'd2: begin
        w_nibble = r_bcd[11:8];
        w_anode  = 3'b011;
      end
      default: begin
        w_nibble = r_bcd[3:0];
        w_anode  = 3'b110;
      end
    endcase
  end

`ifdef DISPLAY_BCD_BLANK_EN
  assign w_blank = ((r_digit_idx == 2'd2) && (r_bcd[11:8] == 4'd0)) ||
                   ((r_digit_idx == 2'd1) && (r_bcd[11:4] == 8'd0));
`else
  assign w_blank = 1'b0;
`endif

  // Anode and segments share one register stage so they always switch on the same edge.
  always_ff @(posedge DISPLAY_BCD_CLOCK_50 or negedge DISPLAY_BCD_Reset_InLow) begin
    if (!DISPLAY_BCD_Reset_InLow) begin
      r_anode <= 3'b110;
      r_seg   <= 7'b1000000;
    end else begin
      r_anode <= w_anode;
      r_seg   <= w_blank ? 7'b1111111 : decode_digit(w_nibble);
    end
  end

  assign DISPLAY_BCD_Busy_Out  = (r_state != S_IDLE);
  assign DISPLAY_BCD_Done_Out  = r_done;
  assign DISPLAY_BCD_BCD_Out   = r_bcd;
  assign DISPLAY_BCD_Seg_Out   = r_seg;
  assign DISPLAY_BCD_Anode_Out = r_anode;

endmodule

// File: tb/tb_display_bcd_driver.sv
// Self-checking bench for display_bcd_driver: table-driven conversions with a done-pulse scoreboard,
// plus busy-ignore, refresh scan, leading-zero display and mid-conversion reset sequences.
module tb_display_bcd_driver;

  logic        clk;
  logic        rstN;
  logic [7:0]  dataIn;
  logic        loadIn;
  logic        busy;
  logic        done;
  logic [11:0] bcdOut;
  logic [6:0]  segOut;
  logic [2:0]  anodeOut;

  int compared   = 0;
  int mismatched = 0;
  int doneCount  = 0;
  logic [11:0] scoreboard[$];

  typedef struct {
    logic [7:0]  data;
    logic [11:0] bcd;
  } vec_t;

  vec_t vecs[10];

  display_bcd_driver #(
    .DATAWIDTH_BUS    (8),
    .DATAWIDTH_REFRESH(16),
    .REFRESH_COUNT    (4)
  ) dut (
    .DISPLAY_BCD_CLOCK_50   (clk),
    .DISPLAY_BCD_Reset_InLow(rstN),
    .DISPLAY_BCD_Data_In    (dataIn),
    .DISPLAY_BCD_Load_In    (loadIn),
    .DISPLAY_BCD_Busy_Out   (busy),
    .DISPLAY_BCD_Done_Out   (done),
    .DISPLAY_BCD_BCD_Out    (bcdOut),
    .DISPLAY_BCD_Seg_Out    (segOut),
    .DISPLAY_BCD_Anode_Out  (anodeOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] segOf(input int d);
    case (d)
      0: segOf = 7'b1000000;
      1: segOf = 7'b1111001;
      2: segOf = 7'b0100100;
      3: segOf = 7'b0110000;
      4: segOf = 7'b0011001;
      5: segOf = 7'b0010010;
      6: segOf = 7'b0000010;
      7: segOf = 7'b1111000;
      8: segOf = 7'b0000000;
      9: segOf = 7'b0010000;
      default: segOf = 7'b1111111;
    endcase
  endfunction

  // Every done pulse must match the oldest expected result; a pulse with nothing queued is an error.
  always @(negedge clk) begin
    if (rstN && done) begin
      doneCount++;
      if (scoreboard.size() == 0) begin
        checkOutput("unexpected_done", 32'd1, 32'd0);
      end else begin
        checkOutput("bcd_out", {20'd0, bcdOut}, {20'd0, scoreboard.pop_front()});
      end
    end
  end

  // Starts at a negedge, ends at the negedge where done is seen so the next load can go back-to-back.
  task automatic applyStimulus(input logic [7:0] data, input logic [11:0] expBcd);
    int cyc;
    dataIn = data;
    loadIn = 1'b1;
    scoreboard.push_back(expBcd);
    @(negedge clk);
    loadIn = 1'b0;
    checkOutput("busy_after_load", {31'd0, busy}, 32'd1);
    cyc = 1;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("done_latency", cyc, 32'd10);
  endtask

  task automatic checkDisplay(input int value, input string tag);
    logic [2:0] prevAnode;
    logic [6:0] expSeg[3];
    logic [2:0] expAnode[3];
    bit found;
    int idx;
    expSeg[0] = segOf(value % 10);
    expSeg[1] = segOf((value / 10) % 10);
    expSeg[2] = segOf(value / 100);
`ifdef DISPLAY_BCD_BLANK_EN
    if (value / 100 == 0) expSeg[2] = 7'b1111111;
    if (value / 10 == 0)  expSeg[1] = 7'b1111111;
`endif
    expAnode[0] = 3'b110;
    expAnode[1] = 3'b101;
    expAnode[2] = 3'b011;
    found = 1'b0;
    prevAnode = anodeOut;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clk);
      if (prevAnode == 3'b011 && anodeOut == 3'b110) found = 1'b1;
      prevAnode = anodeOut;
    end
    checkOutput({tag, "_scan_found"}, {31'd0, found}, 32'd1);
    if (found) begin
      for (int i = 0; i < 24; i++) begin
        idx = (i / 4) % 3;
        checkOutput({tag, "_anode_seg"}, {22'd0, anodeOut, segOut}, {22'd0, expAnode[idx], expSeg[idx]});
        @(negedge clk);
      end
    end
  endtask

  initial begin
    int startDone;
    vecs[0] = '{8'd255, 12'h255};
    vecs[1] = '{8'd0,   12'h000};
    vecs[2] = '{8'd100, 12'h100};
    vecs[3] = '{8'd99,  12'h099};
    vecs[4] = '{8'd7,   12'h007};
    vecs[5] = '{8'd1,   12'h001};
    vecs[6] = '{8'd9,   12'h009};
    vecs[7] = '{8'd10,  12'h010};
    vecs[8] = '{8'd200, 12'h200};
    vecs[9] = '{8'd219, 12'h219};

    rstN = 1'b0;
    dataIn = 8'd0;
    loadIn = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy",  {31'd0, busy},     32'd0);
    checkOutput("reset_done",  {31'd0, done},     32'd0);
    checkOutput("reset_bcd",   {20'd0, bcdOut},   32'h000);
    checkOutput("reset_anode", {29'd0, anodeOut}, 32'b110);
    checkOutput("reset_seg",   {25'd0, segOut},   32'b1000000);
    rstN = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 10; v++) begin
      applyStimulus(vecs[v].data, vecs[v].bcd);
    end

    checkDisplay(219, "scan219");

    // Loads while busy are dropped: only the 123 conversion completes.
    startDone = doneCount;
    dataIn = 8'd123;
    loadIn = 1'b1;
    scoreboard.push_back(12'h123);
    @(negedge clk);
    dataIn = 8'd45;
    repeat (8) @(negedge clk);
    loadIn = 1'b0;
    repeat (15) @(negedge clk);
    checkOutput("busy_ignore_done_count", doneCount - startDone, 32'd1);
    checkOutput("busy_ignore_bcd", {20'd0, bcdOut}, 32'h123);

    applyStimulus(8'd7, 12'h007);
    checkDisplay(7, "scan7");

    // Reset during the fourth conversion cycle must abort with no done pulse.
    startDone = doneCount;
    dataIn = 8'd255;
    loadIn = 1'b1;
    @(negedge clk);
    loadIn = 1'b0;
    repeat (3) @(negedge clk);
    rstN = 1'b0;
    #1;
    checkOutput("abort_busy",  {31'd0, busy},     32'd0);
    checkOutput("abort_bcd",   {20'd0, bcdOut},   32'h000);
    checkOutput("abort_anode", {29'd0, anodeOut}, 32'b110);
    checkOutput("abort_seg",   {25'd0, segOut},   32'b1000000);
    @(negedge clk);
    rstN = 1'b1;
    repeat (15) @(negedge clk);
    checkOutput("abort_no_done", doneCount - startDone, 32'd0);
    checkOutput("abort_bcd_after", {20'd0, bcdOut}, 32'h000);
    checkOutput("scoreboard_empty", scoreboard.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
